axis_write_addr: RTL and testbench

AXIS_WRITE_ADDR -- requirements
Module: axis_write_addr

---
 rtl/axis_write_addr.sv | 166 ++++++++++++++++
 tb/tb_axis_write_addr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_addr.sv
// AXI write-address burst generator: splits a stream-word transfer into full AW bursts plus one tail burst.
// Latency: AW valid one cycle after config accept; done one cycle after the last B response.
// Backpressure: AW address/length held while awready is low; config only accepted in IDLE.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cfg_address/length       start byte address (beat-aligned) and length in stream words
//   cfg_valid/cfg_ready      config handshake, ready only while idle
//   axi_aw*                  burst address, beats-1, valid/ready
//   axi_b*                   write response channel, ready while bursts are outstanding
//   done                     one-cycle completion pulse
//   error                    sticky non-OKAY response flag, cleared on next config accept
module axis_write_addr #(
    parameter int CONFIG_DWIDTH  = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int CONVERT_SHIFT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      done,
    output logic                      error
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    // Low CONVERT_SHIFT bits of the length: any set bit means a partial final beat.
    localparam logic [CONFIG_DWIDTH-1:0] REM_MASK =
        (CONFIG_DWIDTH'(1) << CONVERT_SHIFT) - CONFIG_DWIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ADDR = 4'b0010,
        S_WAIT = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CONFIG_DWIDTH-1:0]    beats_q, beats_d;
    logic [CONFIG_DWIDTH-1:0]    issued_q, issued_d;
    logic [CONFIG_DWIDTH-1:0]    resp_q, resp_d;
    logic [AXI_LEN_WIDTH-1:0]    awlen_q, awlen_d;
    logic                        awvalid_q, awvalid_d;
    logic                        error_q, error_d;

    logic                        cfg_hs, aw_hs, b_hs;
    logic [CONFIG_DWIDTH-1:0]    len_beats;
    logic [CONFIG_DWIDTH-1:0]    burst_beats;
    logic [CONFIG_DWIDTH-1:0]    beats_after_aw;

    // Burst length for the next burst: full when at least 2^AXI_LEN_WIDTH
    // beats remain, otherwise the tail. Only called with b != 0.
    function automatic logic [AXI_LEN_WIDTH-1:0] next_len(input logic [CONFIG_DWIDTH-1:0] b);
        if ((b >> AXI_LEN_WIDTH) != '0)
            return '1;
        else
            return b[AXI_LEN_WIDTH-1:0] - AXI_LEN_WIDTH'(1);
    endfunction

    assign cfg_hs = cfg_valid & cfg_ready;
    assign aw_hs  = awvalid_q & axi_awready;
    assign b_hs   = axi_bvalid & axi_bready;

    // Shift-then-round-up avoids the (len + 2^S - 1) overflow at max length.
    assign len_beats      = (cfg_length >> CONVERT_SHIFT)
                          + CONFIG_DWIDTH'(|(cfg_length & REM_MASK));
    assign burst_beats    = CONFIG_DWIDTH'(awlen_q) + CONFIG_DWIDTH'(1);
    assign beats_after_aw = beats_q - burst_beats;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cfg_valid) state_d = (len_beats != '0) ? S_ADDR : S_DONE;
            S_ADDR: if (aw_hs && (beats_after_aw == '0)) state_d = S_WAIT;
            // A response landing this cycle counts towards completion.
            S_WAIT: if ((resp_q + CONFIG_DWIDTH'(b_hs)) == issued_q) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cfg_ready  = (state_q == S_IDLE);
        axi_bready = (state_q == S_ADDR) || (state_q == S_WAIT);
        done       = (state_q == S_DONE);
    end

    // Datapath next-state
    always_comb begin
        addr_d    = addr_q;
        beats_d   = beats_q;
        issued_d  = issued_q;
        resp_d    = resp_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        error_d   = error_q;
        if (cfg_hs) begin
            addr_d    = cfg_address;
            beats_d   = len_beats;
            issued_d  = '0;
            resp_d    = '0;
            error_d   = 1'b0;
            awvalid_d = (len_beats != '0);
            awlen_d   = (len_beats != '0) ? next_len(len_beats) : '0;
        end else begin
            if (aw_hs) begin
                addr_d    = addr_q + AXI_ADDR_WIDTH'(burst_beats) * AXI_ADDR_WIDTH'(BEAT_BYTES);
                beats_d   = beats_after_aw;
                issued_d  = issued_q + CONFIG_DWIDTH'(1);
                awvalid_d = (beats_after_aw != '0);
                // Keep the last length on the bus once the final burst is gone.
                if (beats_after_aw != '0) awlen_d = next_len(beats_after_aw);
            end
            if (b_hs) begin
                resp_d = resp_q + CONFIG_DWIDTH'(1);
                if (axi_bresp != 2'b00) error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            beats_q   <= '0;
            issued_q  <= '0;
            resp_q    <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            issued_q  <= issued_d;
            resp_q    <= resp_d;
            awlen_q   <= awlen_d;
            awvalid_q <= awvalid_d;
            error_q   <= error_d;
        end
    end

    assign axi_awaddr  = addr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awvalid = awvalid_q;
    assign error       = error_q;

endmodule

// File: tb/tb_axis_write_addr.sv
// Directed bench for axis_write_addr with default parameters.
// Inputs driven and outputs sampled on the falling edge.
// AW/B responders are modelled inline; B follows each AW handshake by a cycle.
module tb_axis_write_addr;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_address;
    logic [31:0] cfg_length;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        done;
    logic        error;

    axis_write_addr #(
        .CONFIG_DWIDTH (32),
        .AXI_ADDR_WIDTH(32),
        .AXI_LEN_WIDTH (8),
        .AXI_DATA_WIDTH(64),
        .CONVERT_SHIFT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_address(cfg_address),
        .cfg_length (cfg_length),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .axi_awaddr (axi_awaddr),
        .axi_awlen  (axi_awlen),
        .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_bresp  (axi_bresp),
        .axi_bvalid (axi_bvalid),
        .axi_bready (axi_bready),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected burst list for the current transfer
    logic [31:0] exp_addr [0:7];
    logic [7:0]  exp_len  [0:7];
    int          exp_n;
    int          stall_burst;
    int          stall_cyc;
    int          bad_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle. Returns the number of
    // cycles after accept at which done was seen.
    task automatic do_xfer(input logic [31:0] a, input logic [31:0] l,
                           input logic exp_err, output int done_cyc);
        int   burst   = 0;
        int   resp    = 0;
        int   pend    = 0;
        int   stalled = 0;
        int   cyc     = 0;
        logic done_seen = 1'b0;
        logic hs_aw, hs_b, bad;
        done_cyc = -1;
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("error_clr_on_accept", error, 0);
        while (!done_seen && cyc < 3000) begin
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end else begin
                axi_awready = 1'b0;
                if (axi_awvalid) begin
                    if (burst < exp_n) begin
                        check("awaddr", axi_awaddr, exp_addr[burst]);
                        check("awlen", {24'd0, axi_awlen}, {24'd0, exp_len[burst]});
                    end else begin
                        check("extra_burst", burst, exp_n);
                    end
                    if (burst == stall_burst && stalled < stall_cyc) stalled++;
                    else axi_awready = 1'b1;
                end
                hs_aw      = axi_awvalid && axi_awready;
                bad        = (resp == bad_idx);
                axi_bvalid = (pend > 0);
                axi_bresp  = bad ? 2'b10 : 2'b00;
                hs_b       = axi_bvalid && axi_bready;
                @(posedge clk);
                @(negedge clk);
                if (hs_aw) begin
                    burst++;
                    pend++;
                end
                if (hs_b) begin
                    if (bad) check("error_set_next", error, 1);
                    resp++;
                    pend--;
                end
                cyc++;
            end
        end
        axi_awready = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        check("done_seen", done_seen, 1);
        check("burst_count", burst, exp_n);
        check("resp_count", resp, exp_n);
        check("error_at_done", error, exp_err);
        check("cfg_ready_in_done", cfg_ready, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("cfg_ready_after", cfg_ready, 1);
        check("error_hold", error, exp_err);
    endtask

    int dc;

    initial begin
        rst         = 1'b1;
        cfg_address = '0;
        cfg_length  = '0;
        cfg_valid   = 1'b0;
        axi_awready = 1'b0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        stall_burst = -1;
        stall_cyc   = 0;
        bad_idx     = -1;
        exp_n       = 0;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_awaddr", axi_awaddr, 0);
        check("rst_awlen", {24'd0, axi_awlen}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1024 words -> 512 beats -> two full bursts
        exp_n = 2;
        exp_addr[0] = 32'h0000_1000; exp_len[0] = 8'd255;
        exp_addr[1] = 32'h0000_1800; exp_len[1] = 8'd255;
        do_xfer(32'h0000_1000, 32'd1024, 1'b0, dc);

        // 3 words -> 2 beats
        exp_n = 1;
        exp_addr[0] = 32'h0000_2000; exp_len[0] = 8'd1;
        do_xfer(32'h0000_2000, 32'd3, 1'b0, dc);

        // 1300 words -> 650 beats -> 256, 256, 138
        exp_n = 3;
        exp_addr[0] = 32'h0001_0000; exp_len[0] = 8'd255;
        exp_addr[1] = 32'h0001_0800; exp_len[1] = 8'd255;
        exp_addr[2] = 32'h0001_1000; exp_len[2] = 8'd137;
        do_xfer(32'h0001_0000, 32'd1300, 1'b0, dc);

        // Zero length: no AW, done right after accept
        exp_n = 0;
        do_xfer(32'h0000_3000, 32'd0, 1'b0, dc);
        check("len0_done_latency", dc, 0);

        // awready stalled 10 cycles on the second burst
        exp_n = 2;
        stall_burst = 1;
        stall_cyc   = 10;
        exp_addr[0] = 32'h0000_4000; exp_len[0] = 8'd255;
        exp_addr[1] = 32'h0000_4800; exp_len[1] = 8'd255;
        do_xfer(32'h0000_4000, 32'd1024, 1'b0, dc);
        stall_burst = -1;
        stall_cyc   = 0;

        // SLVERR on the first response, sticky past done
        bad_idx = 0;
        exp_addr[0] = 32'h0000_8000; exp_len[0] = 8'd255;
        exp_addr[1] = 32'h0000_8800; exp_len[1] = 8'd255;
        do_xfer(32'h0000_8000, 32'd1024, 1'b1, dc);
        bad_idx = -1;

        // Next accept clears error; address wraps past 2^32
        exp_addr[0] = 32'hFFFF_F800; exp_len[0] = 8'd255;
        exp_addr[1] = 32'h0000_0000; exp_len[1] = 8'd255;
        do_xfer(32'hFFFF_F800, 32'd1024, 1'b0, dc);

        // Max length, then reset with a burst outstanding
        cfg_address = 32'h0002_0000;
        cfg_length  = 32'hFFFF_FFFF;
        cfg_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("max_awvalid", axi_awvalid, 1);
        check("max_awaddr", axi_awaddr, 32'h0002_0000);
        check("max_awlen", {24'd0, axi_awlen}, 32'd255);
        axi_awready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_awready = 1'b0;
        check("max_awaddr2", axi_awaddr, 32'h0002_0800);
        rst        = 1'b1;
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_awvalid", axi_awvalid, 0);
        check("mid_rst_bready", axi_bready, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_awaddr", axi_awaddr, 0);
        @(posedge clk);
        @(negedge clk);
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        check("late_b_ignored", error, 0);
        check("late_no_done", done, 0);

        // Recovery after reset
        exp_n = 1;
        exp_addr[0] = 32'h0000_5000; exp_len[0] = 8'd1;
        do_xfer(32'h0000_5000, 32'd4, 1'b0, dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
